// File: rtl/digit_token_packer.sv
// Generic synchronous FIFO, registered storage with the head slot read combinationally.
// Latency: a written entry is visible at rd_dat/rd_vld from the edge that writes it.
// Backpressure: wr_rdy drops only when full with no pop on the same edge; rd side is valid/ready.
//
// Ports: clk/rst (async active-high), wr_vld/wr_dat/wr_rdy write side,
//        rd_vld/rd_dat/rd_rdy read side, count = occupied entries.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (count != '0);
    assign do_rd  = rd_vld && rd_rdy;
    // A pop on the same edge frees the slot, so a full FIFO can still take a write.
    assign wr_rdy = (count != FULL_CNT) || do_rd;
    assign do_wr  = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Converts space-terminated ASCII decimal digit runs into {value, digit count, overflow} entries.
// Latency: entry pushed on the edge sampling the terminating space; out_valid rises from that edge.
// Backpressure: none on the character input; full FIFO drops the token and sets sticky overrun.
//
// Ports: clk/rst (async active-high), in_data/in_write character stream,
//        out_value/out_digits/out_ovf/out_valid/out_ready FIFO head and handshake,
//        fifo_count occupancy, overrun sticky drop flag.
module digit_token_packer #(
    parameter int VAL_W = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_write,
    output logic [VAL_W-1:0]         out_value,
    output logic [CNT_W-1:0]         out_digits,
    output logic                     out_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun
);
    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic [CNT_W-1:0] digits;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [VAL_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             push_vld;
    logic             push_rdy;
    entry_t           push_dat;
    entry_t           head_dat;

    logic             is_digit;
    logic             is_space;
    logic [VAL_W-1:0] digit_val;
    logic [VAL_W+3:0] acc_next_wide;

    assign is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_space  = (in_data == 8'h20);
    assign digit_val = {{(VAL_W-4){1'b0}}, in_data[3:0]};
    // Four spare bits hold acc*10+9 for any acc, so the overflow test is just the top nibble.
    assign acc_next_wide = ({4'b0, acc} * (VAL_W+4)'(10)) + {4'b0, digit_val};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        push_vld  = 1'b0;
        if (in_write) begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        state_nxt = ACCUM;
                        acc_nxt   = digit_val;
                        cnt_nxt   = CNT_W'(1);
                        ovf_nxt   = 1'b0;
                    end else if (!is_space) begin
                        state_nxt = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        if (|acc_next_wide[VAL_W+3:VAL_W]) begin
                            acc_nxt = '1;
                            ovf_nxt = 1'b1;
                        end else begin
                            acc_nxt = acc_next_wide[VAL_W-1:0];
                        end
                        if (cnt != '1) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else if (is_space) begin
                        push_vld  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_space) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign push_dat = '{value: acc, digits: cnt, ovf: ovf};

    sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .wr_rdy (push_rdy),
        .rd_vld (out_valid),
        .rd_dat (head_dat),
        .rd_rdy (out_ready),
        .count  (fifo_count)
    );

    assign out_value  = head_dat.value;
    assign out_digits = head_dat.digits;
    assign out_ovf    = head_dat.ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (push_vld && !push_rdy) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_digit_token_packer.sv
// Self-checking bench for digit_token_packer: directed scenarios plus randomized
// character streams, with a string-level reference model feeding a scoreboard queue.
module tb_digit_token_packer;
    localparam int VAL_W = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [7:0]             in_data = 8'h00;
    logic                   in_write = 1'b0;
    logic [VAL_W-1:0]       out_value;
    logic [CNT_W-1:0]       out_digits;
    logic                   out_ovf;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overrun;

    digit_token_packer #(.VAL_W(VAL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_write   (in_write),
        .out_value  (out_value),
        .out_digits (out_digits),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int digits;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    byte  tok[$];
    int   m_count = 0;
    bit   m_ovr   = 1'b0;
    bit   mon_en  = 1'b0;
    int   checks  = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: the token is a decimal numeral string.
    function automatic exp_t convert(input byte t[$]);
        exp_t e;
        int   first = 0;
        int   sig;
        int   v = 0;
        while (first < t.size() - 1 && t[first] == 8'h30) first++;
        sig = t.size() - first;
        e.digits = (t.size() > 15) ? 15 : t.size();
        if (sig > 5) begin
            e.value = 65535;
            e.ovf   = 1'b1;
        end else begin
            for (int j = first; j < t.size(); j++) v = v * 10 + (int'(t[j]) - 48);
            e.ovf   = (v > 65535);
            e.value = e.ovf ? 65535 : v;
        end
        return e;
    endfunction

    function automatic bit all_digits(input byte t[$]);
        foreach (t[i]) if (t[i] < 8'h30 || t[i] > 8'h39) return 1'b0;
        return 1'b1;
    endfunction

    // Called at posedge+1; drives one cycle of input and advances the model past the edge.
    task automatic send(input byte c, input bit wr, input bit rdy);
        bit   pop;
        bit   push = 1'b0;
        bit   ovr_pend = 1'b0;
        exp_t e;
        in_data   = c;
        in_write  = wr;
        out_ready = rdy;
        pop = rdy && (m_count > 0);
        if (wr) begin
            if (c == 8'h20) begin
                if (tok.size() > 0 && all_digits(tok)) begin
                    e = convert(tok);
                    if (m_count < DEPTH || pop) begin
                        exp_q.push_back(e);
                        push = 1'b1;
                    end else begin
                        ovr_pend = 1'b1;
                    end
                end
                tok.delete();
            end else begin
                tok.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        m_count = m_count + int'(push) - int'(pop);
        m_ovr   = m_ovr | ovr_pend;
    endtask

    task automatic send_str(input string s, input bit rdy);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) send(8'h00, 1'b0, rdy);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_value"},  out_value, 0);
        chk({tag, "_digits"}, out_digits, 0);
        chk({tag, "_ovf"},    out_ovf, 0);
        chk({tag, "_valid"},  out_valid, 0);
        chk({tag, "_count"},  fifo_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Asynchronous reset asserted between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        in_write = 1'b0;
        out_ready = 1'b0;
        tok.delete();
        exp_q.delete();
        m_count = 0;
        m_ovr = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares the presented head and pops it on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_valid", out_valid, (m_count > 0));
            chk("mon_count", fifo_count, m_count);
            chk("mon_overrun", overrun, m_ovr);
            if (m_count > 0 && exp_q.size() > 0) begin
                chk("mon_value",  out_value,  exp_q[0].value);
                chk("mon_digits", out_digits, exp_q[0].digits);
                chk("mon_ovf",    out_ovf,    exp_q[0].ovf);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int   len;
        bit   rdy_bias;
        byte  c;
        byte  run[$];
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: single token, consumer always ready
        send_str("729 ", 1'b1);
        chk("t1_value", out_value, 729);
        chk("t1_digits", out_digits, 3);
        idle(2, 1'b1);

        // 2: saturation boundary
        send_str("99999 ", 1'b0);
        chk("t2_sat_value", out_value, 65535);
        chk("t2_sat_ovf", out_ovf, 1);
        chk("t2_sat_digits", out_digits, 5);
        idle(2, 1'b1);
        send_str("65535 ", 1'b0);
        chk("t2_max_value", out_value, 65535);
        chk("t2_max_ovf", out_ovf, 0);
        idle(2, 1'b1);
        send_str("007 65536 ", 1'b1);
        idle(2, 1'b1);

        // 3: non-digit kills a token, double space yields nothing
        send_str("12a4 5  ", 1'b0);
        chk("t3_count", fifo_count, 1);
        chk("t3_value", out_value, 5);
        idle(3, 1'b1);

        // 5: push into a full FIFO while popping
        do_reset();
        send_str("1 2 3 4 8", 1'b0);
        chk("t5_full", fifo_count, 4);
        send(8'h20, 1'b1, 1'b1);
        chk("t5_count", fifo_count, 4);
        chk("t5_overrun", overrun, 0);
        idle(6, 1'b1);

        // 4: overflow drops the fifth token, drain keeps order
        send_str("1 2 3 4 5 ", 1'b0);
        chk("t4_count", fifo_count, 4);
        chk("t4_overrun", overrun, 1);
        idle(6, 1'b1);

        // 6: async reset mid-token with a queued entry
        idle(1, 1'b0);
        send_str("3 56", 1'b0);
        do_reset();
        send_str("7 ", 1'b0);
        chk("t6_count", fifo_count, 1);
        chk("t6_value", out_value, 7);
        idle(3, 1'b1);

        // Randomized streams
        for (int t = 0; t < 250; t++) begin
            run.delete();
            len = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 5) : $urandom_range(6, 20);
            for (int i = 0; i < len; i++) run.push_back(8'(8'h30 + $urandom_range(0, 9)));
            if ($urandom_range(0, 7) == 0) run[$urandom_range(0, len - 1)] = ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h2d;
            for (int i = 0; i < $urandom_range(1, 2); i++) run.push_back(8'h20);
            if (t % 16 == 0) rdy_bias = ~rdy_bias;
            foreach (run[i]) begin
                while ($urandom_range(0, 4) == 0) begin
                    c = 8'($urandom_range(0, 255));
                    send(c, 1'b0, rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
                end
                send(run[i], 1'b1, rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            end
        end

        idle(8, 1'b1);
        chk("final_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
